// File: rtl/bist_tdr.sv
// BIST test data register on the JTAG DR path: capture/shift/update with a shadow stage.
// Holds one {state, x, y} vector; readback returns configured state/x plus the BIST result.
module bist_tdr #(
    parameter int STATE_W = 4,
    parameter int X_W     = 1024,
    parameter int Y_W     = 1024
) (
    input  logic               TCK,
    input  logic               RST,
    input  logic               SEL,
    input  logic               CAPTURE_DR,
    input  logic               SHIFT_DR,
    input  logic               UPDATE_DR,
    input  logic               TDI,
    input  logic [Y_W-1:0]     RESULT_IN,
    output logic               TDO,
    output logic [STATE_W-1:0] STATE_Q,
    output logic [X_W-1:0]     X_Q,
    output logic [Y_W-1:0]     Y_Q,
    output logic               UPD_STB,
    output logic               UPD_ERR
);

    localparam int DR_LEN = STATE_W + X_W + Y_W;
    localparam int CNT_W  = $clog2(DR_LEN + 2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DR_LEN);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DR_LEN + 1);

    logic [DR_LEN-1:0] sr;
    logic [CNT_W-1:0]  cnt;
    logic              do_cap;
    logic              do_upd;
    logic              do_shift;

    // Stops at DR_LEN+1 so any overshift stays distinguishable from an exact-length shift.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == CNT_MAX) ? c : c + CNT_W'(1);
    endfunction

    always_comb begin
        do_cap   = 1'b0;
        do_upd   = 1'b0;
        do_shift = 1'b0;
        if (SEL) begin
            do_cap   = CAPTURE_DR;
            do_upd   = UPDATE_DR & ~CAPTURE_DR;
            do_shift = SHIFT_DR & ~CAPTURE_DR & ~UPDATE_DR;
        end
    end

    always_ff @(posedge TCK or posedge RST) begin
        if (RST) begin
            sr      <= '0;
            cnt     <= '0;
            TDO     <= 1'b0;
            STATE_Q <= '0;
            X_Q     <= '0;
            Y_Q     <= '0;
            UPD_STB <= 1'b0;
            UPD_ERR <= 1'b0;
        end else begin
            UPD_STB <= 1'b0;
            UPD_ERR <= 1'b0;
            if (do_cap) begin
                sr  <= {STATE_Q, X_Q, RESULT_IN};
                cnt <= '0;
            end else if (do_upd) begin
                // cnt is left alone so a repeated update re-tests the same shift
                if (cnt == CNT_FULL) begin
                    {STATE_Q, X_Q, Y_Q} <= sr;
                    UPD_STB             <= 1'b1;
                end else begin
                    UPD_ERR <= 1'b1;
                end
            end else if (do_shift) begin
                TDO <= sr[0];
                sr  <= {TDI, sr[DR_LEN-1:1]};
                cnt <= sat_inc(cnt);
            end
        end
    end

endmodule

// File: tb/tb_bist_tdr.sv
// Bench for bist_tdr: small (2/3/3) instance against a queue-based DR model,
// plus a default-size instance exercised with full-length random vectors.
module tb_bist_tdr;

    localparam int SW = 2, XW = 3, YW = 3, DL = 8;
    localparam int DSW = 4, DXW = 1024, DYW = 1024, DDL = DSW + DXW + DYW;
    localparam logic [3:0] IDLE = 4'b0000, CAP = 4'b1100, SHF = 4'b1010, UPD = 4'b1001;
    localparam logic [YW-1:0] R0 = '0;

    logic tck = 1'b0, rst = 1'b1;
    logic sel = 1'b0, cap = 1'b0, shf = 1'b0, upd = 1'b0, tdi = 1'b0;
    logic [YW-1:0] res = '0;
    logic tdo, stb, err;
    logic [SW-1:0] sq;
    logic [XW-1:0] xq;
    logic [YW-1:0] yq;
    logic [10:0] got;

    logic dsel = 1'b0, dcap = 1'b0, dshf = 1'b0, dupd = 1'b0, dtdi = 1'b0;
    logic [DYW-1:0] dres = '0;
    logic dtdo, dstb, derr;
    logic [DSW-1:0] dsq;
    logic [DXW-1:0] dxq;
    logic [DYW-1:0] dyq;

    bist_tdr #(.STATE_W(SW), .X_W(XW), .Y_W(YW)) u_small (
        .TCK(tck), .RST(rst), .SEL(sel), .CAPTURE_DR(cap), .SHIFT_DR(shf), .UPDATE_DR(upd),
        .TDI(tdi), .RESULT_IN(res), .TDO(tdo), .STATE_Q(sq), .X_Q(xq), .Y_Q(yq),
        .UPD_STB(stb), .UPD_ERR(err)
    );

    bist_tdr u_def (
        .TCK(tck), .RST(rst), .SEL(dsel), .CAPTURE_DR(dcap), .SHIFT_DR(dshf), .UPDATE_DR(dupd),
        .TDI(dtdi), .RESULT_IN(dres), .TDO(dtdo), .STATE_Q(dsq), .X_Q(dxq), .Y_Q(dyq),
        .UPD_STB(dstb), .UPD_ERR(derr)
    );

    always #5 tck = ~tck;
    assign got = {tdo, sq, xq, yq, stb, err};

    // Reference model: DR contents as a bit FIFO, LSB (next bit out) at the front.
    bit mq[$];
    logic [SW-1:0] ms;
    logic [XW-1:0] mx;
    logic [YW-1:0] my;
    int mcnt;
    logic mtdo, mstb, merr;
    int n_pass = 0, n_total = 0;

    function automatic logic [10:0] expo();
        return {mtdo, ms, mx, my, mstb, merr};
    endfunction

    task automatic model_reset();
        mq.delete();
        for (int i = 0; i < DL; i++) mq.push_back(1'b0);
        ms = '0; mx = '0; my = '0; mcnt = 0; mtdo = 1'b0; mstb = 1'b0; merr = 1'b0;
    endtask

    task automatic step(input logic [3:0] q, input logic t, input logic [YW-1:0] r);
        logic [DL-1:0] v;
        {sel, cap, shf, upd} = q;
        tdi = t; res = r; dsel = 1'b0;
        @(posedge tck);
        mstb = 1'b0; merr = 1'b0;
        if (q[3]) begin
            if (q[2]) begin
                v = {ms, mx, r};
                mq.delete();
                for (int i = 0; i < DL; i++) mq.push_back(v[i]);
                mcnt = 0;
            end else if (q[0]) begin
                if (mcnt == DL) begin
                    for (int i = 0; i < DL; i++) v[i] = mq[i];
                    {ms, mx, my} = v;
                    mstb = 1'b1;
                end else begin
                    merr = 1'b1;
                end
            end else if (q[1]) begin
                mtdo = mq.pop_front();
                mq.push_back(t);
                mcnt = (mcnt >= DL + 1) ? DL + 1 : mcnt + 1;
            end
        end
        #1;
    endtask

    task automatic dstep(input logic c, input logic s, input logic u, input logic t);
        dsel = 1'b1; dcap = c; dshf = s; dupd = u; dtdi = t; sel = 1'b0;
        @(posedge tck);
        #1;
    endtask

    task automatic test_reset();
        #12;
        n_total++;
        if ({got, dtdo, dsq, dstb, derr} !== '0) $display("FAIL reset_outputs got=%h dsq=%h exp=0", got, dsq);
        else n_pass++;
        n_total++;
        if ({dxq, dyq} !== '0) $display("FAIL reset_def_shadow got_nonzero exp=0");
        else n_pass++;
        @(negedge tck);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_capture_shift();
        logic [DL-1:0] pat;
        pat = 8'b00000101;
        step(CAP, 1'b0, 3'b101);
        for (int k = 1; k <= DL; k++) begin
            step(SHF, 1'b0, R0);
            n_total++;
            if (tdo !== pat[k-1] || got !== expo())
                $display("FAIL cap_shift k=%0d tdo=%b exp=%b got=%h model=%h", k, tdo, pat[k-1], got, expo());
            else n_pass++;
        end
        step(UPD, 1'b0, R0);
        n_total++;
        if ({sq, xq, yq, stb, err} !== {8'h00, 2'b10}) $display("FAIL cap_shift_update got=%h exp=%h", got, {1'b0, 8'h00, 2'b10});
        else n_pass++;
    endtask

    task automatic test_load();
        logic [DL-1:0] v;
        v = 8'b10_110_011;
        step(CAP, 1'b0, YW'($urandom));
        for (int k = 0; k < DL; k++) step(SHF, v[k], R0);
        step(UPD, 1'b0, R0);
        n_total++;
        if (sq !== 2'b10 || xq !== 3'b110 || yq !== 3'b011 || stb !== 1'b1 || err !== 1'b0)
            $display("FAIL load_shadow got=%b_%b_%b stb=%b err=%b exp=10_110_011 stb=1 err=0", sq, xq, yq, stb, err);
        else n_pass++;
        step(IDLE, 1'b0, R0);
        n_total++;
        if (stb !== 1'b0 || got !== expo()) $display("FAIL load_stb_pulse got=%h exp=%h", got, expo());
        else n_pass++;
    endtask

    task automatic test_readback();
        logic [DL-1:0] pat;
        int bad;
        pat = 8'b10_110_111;
        bad = 0;
        step(CAP, 1'b0, 3'b111);
        for (int k = 1; k <= DL; k++) begin
            step(SHF, 1'($urandom_range(0, 1)), R0);
            if (tdo !== pat[k-1] || got !== expo()) bad++;
        end
        n_total++;
        if (bad != 0) $display("FAIL readback_stream bad_bits=%0d exp=0", bad);
        else n_pass++;
    endtask

    task automatic test_async_reset();
        step(CAP, 1'b0, 3'b110);
        for (int k = 0; k < 3; k++) step(SHF, 1'b1, R0);
        {sel, cap, shf, upd} = IDLE;
        #2 rst = 1'b1;
        #1;
        n_total++;
        if ({got, dtdo, dsq, dstb, derr} !== '0) $display("FAIL async_reset got=%h exp=0", got);
        else n_pass++;
        #1 rst = 1'b0;
        model_reset();
        step(UPD, 1'b0, R0);
        n_total++;
        if (err !== 1'b1 || stb !== 1'b0 || got !== expo()) $display("FAIL reset_then_update got=%h exp=%h", got, expo());
        else n_pass++;
        step(CAP, 1'b0, R0);
        for (int k = 0; k < DL; k++) step(SHF, k[0], R0);
        step(UPD, 1'b0, R0);
        n_total++;
        if (got !== expo() || stb !== 1'b1) $display("FAIL reload_after_reset got=%h exp=%h", got, expo());
        else n_pass++;
    endtask

    task automatic test_bad_count();
        int lens[3];
        lens = '{7, 9, 200};
        foreach (lens[j]) begin
            step(CAP, 1'b0, YW'($urandom));
            for (int k = 0; k < lens[j]; k++) step(SHF, 1'($urandom_range(0, 1)), R0);
            step(UPD, 1'b0, R0);
            n_total++;
            if (err !== 1'b1 || stb !== 1'b0 || got !== expo())
                $display("FAIL bad_count len=%0d got=%h exp=%h", lens[j], got, expo());
            else n_pass++;
            step(IDLE, 1'b0, R0);
            n_total++;
            if (err !== 1'b0 || got !== expo()) $display("FAIL bad_count_pulse len=%0d got=%h exp=%h", lens[j], got, expo());
            else n_pass++;
        end
    endtask

    task automatic test_sel_low();
        int bad;
        bad = 0;
        step(CAP, 1'b0, YW'($urandom));
        for (int k = 0; k < DL; k++) step(SHF, 1'($urandom_range(0, 1)), R0);
        for (int k = 0; k < 20; k++) begin
            step({1'b0, 3'($urandom)}, 1'($urandom_range(0, 1)), YW'($urandom));
            if (got !== expo()) bad++;
        end
        n_total++;
        if (bad != 0) $display("FAIL sel_low_hold bad_cycles=%0d exp=0", bad);
        else n_pass++;
        step(UPD, 1'b0, R0);
        n_total++;
        if (stb !== 1'b1 || got !== expo()) $display("FAIL sel_low_update got=%h exp=%h", got, expo());
        else n_pass++;
        step(UPD, 1'b0, R0);
        n_total++;
        if (stb !== 1'b1 || got !== expo()) $display("FAIL second_update got=%h exp=%h", got, expo());
        else n_pass++;
        step(4'b1110, 1'b1, 3'b010);
        n_total++;
        if (got !== expo()) $display("FAIL cap_and_shift got=%h exp=%h", got, expo());
        else n_pass++;
        for (int k = 0; k < DL; k++) step(SHF, 1'($urandom_range(0, 1)), R0);
        step(4'b1011, 1'b1, R0);
        n_total++;
        if (stb !== 1'b1 || got !== expo()) $display("FAIL upd_and_shift got=%h exp=%h", got, expo());
        else n_pass++;
    endtask

    task automatic test_random();
        int n, bad;
        bad = 0;
        for (int t = 0; t < 40; t++) begin
            step({1'b0, 3'($urandom)}, 1'b0, R0);
            if (got !== expo()) bad++;
            step(CAP, 1'b0, YW'($urandom));
            n = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 12)) : DL;
            for (int k = 0; k < n; k++) begin
                if ($urandom_range(0, 5) == 0) begin
                    step(IDLE, 1'b1, R0);
                    if (got !== expo()) bad++;
                end
                step(SHF, 1'($urandom_range(0, 1)), R0);
                if (got !== expo()) bad++;
            end
            step(UPD, 1'b0, R0);
            if (got !== expo()) bad++;
        end
        n_total++;
        if (bad != 0) $display("FAIL random_txn bad_cycles=%0d exp=0", bad);
        else n_pass++;
    endtask

    task automatic test_defaults();
        logic [DDL-1:0] v, capv;
        logic [DYW-1:0] r2;
        int bad;
        for (int i = 0; i < DDL; i++) v[i] = 1'($urandom_range(0, 1));
        dres = {32{$urandom}};
        capv = {{DSW{1'b0}}, {DXW{1'b0}}, dres};
        bad = 0;
        dstep(1'b1, 1'b0, 1'b0, 1'b0);
        for (int k = 1; k <= DDL; k++) begin
            dstep(1'b0, 1'b1, 1'b0, v[k-1]);
            if (dtdo !== capv[k-1]) bad++;
        end
        n_total++;
        if (bad != 0) $display("FAIL def_load_stream bad_bits=%0d exp=0", bad);
        else n_pass++;
        dstep(1'b0, 1'b0, 1'b1, 1'b0);
        n_total++;
        if ({dsq, dxq, dyq} !== v || dstb !== 1'b1 || derr !== 1'b0)
            $display("FAIL def_load_shadow state=%h exp=%h stb=%b", dsq, v[DDL-1 -: DSW], dstb);
        else n_pass++;
        r2 = {32{$urandom}};
        dres = r2;
        capv = {v[DDL-1 -: DSW + DXW], r2};
        bad = 0;
        dstep(1'b1, 1'b0, 1'b0, 1'b0);
        for (int k = 1; k <= DDL; k++) begin
            dstep(1'b0, 1'b1, 1'b0, 1'b0);
            if (dtdo !== capv[k-1]) bad++;
        end
        n_total++;
        if (bad != 0) $display("FAIL def_readback_stream bad_bits=%0d exp=0", bad);
        else n_pass++;
        dstep(1'b0, 1'b1, 1'b0, 1'b0);
        dstep(1'b0, 1'b0, 1'b1, 1'b0);
        n_total++;
        if (derr !== 1'b1 || dstb !== 1'b0 || {dsq, dxq, dyq} !== v)
            $display("FAIL def_overshift err=%b stb=%b exp err=1 stb=0", derr, dstb);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_capture_shift();
        test_load();
        test_readback();
        test_async_reset();
        test_load();
        test_bad_count();
        test_sel_low();
        test_random();
        test_defaults();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
